// File: rtl/ni_rd_histogram_reader_if.sv
// Beat stream from the histogram reader to the feature/classifier stage.
// Each beat carries one bin index with its NI and RD counts.
interface ni_rd_histogram_reader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 24
);
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_bin;
  logic [CNT_W-1:0] o_ni_cnt;
  logic [CNT_W-1:0] o_rd_cnt;
  logic             o_last;

  modport master (output o_valid, o_bin, o_ni_cnt, o_rd_cnt, o_last, input i_ready);
  modport slave  (input  o_valid, o_bin, o_ni_cnt, o_rd_cnt, o_last, output i_ready);
endinterface

// File: rtl/ni_rd_histogram_reader.sv
// NI/RD histogram read-out: walks both count RAMs bin by bin and streams them downstream.
// Build option HIST_CLEAR_ON_READ_EN: zero each bin in both RAMs as it is captured.
//
// state   | meaning
// IDLE    | waiting for i_start
// FETCH   | o_ram_addr = current bin, RAM samples it
// WAIT    | RAM_LAT cycles for read data to settle
// CAPTURE | register read data and bin index (clear the bin when enabled)
// SEND    | o_valid high, hold payload until i_ready
// DONE    | one-cycle o_done pulse
module ni_rd_histogram_reader #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2**WIDTH,
  parameter int CNT_W   = 24,
  parameter int RAM_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [WIDTH-1:0]         o_ram_addr,
  output logic                     o_ram_wren,
  output logic [CNT_W-1:0]         o_ram_wdata,
  input  logic [CNT_W-1:0]         i_ni_rdata,
  input  logic [CNT_W-1:0]         i_rd_rdata,
  output logic [CNT_W+WIDTH-1:0]   o_ni_total,
  ni_rd_histogram_reader_if.master m_if
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_LAT - 1);
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CAPTURE, S_SEND, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_idx;
  logic [LAT_W-1:0]       r_wait_cnt;
  logic [WIDTH-1:0]       r_bin;
  logic [CNT_W-1:0]       r_ni_cnt;
  logic [CNT_W-1:0]       r_rd_cnt;
  logic                   r_last;
  logic [CNT_W+WIDTH-1:0] r_ni_total;
  logic                   w_hs;

  assign w_hs = m_if.o_valid && m_if.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_WAIT;
      S_WAIT:    if (r_wait_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_SEND;
      S_SEND:    if (w_hs) w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Address stays on r_idx from FETCH through CAPTURE; it only moves on a handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_bin      <= '0;
      r_ni_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_last     <= 1'b0;
      r_ni_total <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx      <= '0;
            r_ni_total <= '0;
          end
        end
        S_FETCH: r_wait_cnt <= LAT_LOAD;
        S_WAIT: begin
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - LAT_W'(1);
        end
        S_CAPTURE: begin
          r_bin    <= r_idx;
          r_ni_cnt <= i_ni_rdata;
          r_rd_cnt <= i_rd_rdata;
          r_last   <= (r_idx == LAST_IDX);
        end
        S_SEND: begin
          if (w_hs) begin
            r_ni_total <= r_ni_total + {{WIDTH{1'b0}}, r_ni_cnt};
            if (r_idx != LAST_IDX) r_idx <= r_idx + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_ram_addr    = r_idx;
  assign o_ram_wdata   = '0;
  assign o_ni_total    = r_ni_total;
  assign m_if.o_valid  = (r_state == S_SEND);
  assign m_if.o_bin    = r_bin;
  assign m_if.o_ni_cnt = r_ni_cnt;
  assign m_if.o_rd_cnt = r_rd_cnt;
  assign m_if.o_last   = r_last;

`ifdef HIST_CLEAR_ON_READ_EN
  assign o_ram_wren = (r_state == S_CAPTURE);
`else
  assign o_ram_wren = 1'b0;
`endif

endmodule
